// File: rtl/lock_ctrl_fsm.sv
// ============================================================================
// Module   : lock_ctrl_fsm
// Purpose  : Master FSM of the 4-digit password lock (entry, compare, timers).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_ctrl_fsm #(
    parameter logic [15:0] RESET_PWD    = 16'h1234,
    parameter int          MAX_ERR      = 3,
    parameter int          UNLOCK_TICKS = 1000000,
    parameter int          ERROR_TICKS  = 500000,
    parameter int          ALARM_TICKS  = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    output logic [2:0]  o_current_state,
    output logic [15:0] o_code,
    output logic [3:0]  o_error_times,
    output logic [19:0] o_count_clk,
    output logic        o_door_open
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_INPUT  = 3'd1;
    localparam logic [2:0] S_UNLOCK = 3'd2;
    localparam logic [2:0] S_ERROR  = 3'd3;
    localparam logic [2:0] S_ALARM  = 3'd4;
    localparam logic [2:0] S_ADMIN  = 3'd5;

    localparam logic [15:0] c_BLANK   = 16'hAAAA;
    localparam logic [3:0]  c_K_ENTER = 4'hA;
    localparam logic [3:0]  c_K_CLEAR = 4'hB;
    localparam logic [3:0]  c_K_ADMIN = 4'hC;

    localparam logic [19:0] c_UNLOCK_T = 20'(UNLOCK_TICKS);
    localparam logic [19:0] c_ERROR_T  = 20'(ERROR_TICKS);
    localparam logic [19:0] c_ALARM_T  = 20'(ALARM_TICKS);
    localparam logic [4:0]  c_MAX_ERR  = 5'(MAX_ERR);

    logic [2:0]  r_state;
    logic [15:0] r_code;
    logic [2:0]  r_cnt;
    logic [3:0]  r_err;
    logic [19:0] r_timer;
    logic [15:0] r_pwd;

    logic        w_digit;
    logic        w_enter;
    logic        w_clear;
    logic        w_admin;
    logic        w_full;
    logic        w_expire;
    logic [4:0]  w_err_next;
    logic [3:0]  w_err_sat;
    logic [15:0] w_code_shift;

    assign w_digit      = i_key_valid && (i_key_code <= 4'd9);
    assign w_enter      = i_key_valid && (i_key_code == c_K_ENTER);
    assign w_clear      = i_key_valid && (i_key_code == c_K_CLEAR);
    assign w_admin      = i_key_valid && (i_key_code == c_K_ADMIN);
    assign w_full       = (r_cnt == 3'd4);
    // <=1 instead of ==1 keeps a zero-length timer from wrapping to 2^20-1
    assign w_expire     = i_tick && (r_timer <= 20'd1);
    assign w_err_next   = {1'b0, r_err} + 5'd1;
    assign w_err_sat    = (r_err == 4'hF) ? 4'hF : w_err_next[3:0];
    assign w_code_shift = {r_code[11:0], i_key_code};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT;
            r_code  <= c_BLANK;
            r_cnt   <= 3'd0;
            r_err   <= 4'd0;
            r_timer <= 20'd0;
            r_pwd   <= RESET_PWD;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_digit) begin
                        r_state <= S_INPUT;
                        r_code  <= w_code_shift;
                        r_cnt   <= 3'd1;
                    end
                end
                S_INPUT: begin
                    if (w_digit && !w_full) begin
                        r_code <= w_code_shift;
                        r_cnt  <= r_cnt + 3'd1;
                    end else if (w_clear) begin
                        r_code <= c_BLANK;
                        r_cnt  <= 3'd0;
                    end else if (w_enter && w_full) begin
                        r_code <= c_BLANK;
                        r_cnt  <= 3'd0;
                        if (r_code == r_pwd) begin
                            r_state <= S_UNLOCK;
                            r_err   <= 4'd0;
                            r_timer <= c_UNLOCK_T;
                        end else if (w_err_next < c_MAX_ERR) begin
                            r_state <= S_ERROR;
                            r_err   <= w_err_sat;
                            r_timer <= c_ERROR_T;
                        end else begin
                            r_state <= S_ALARM;
                            r_err   <= w_err_sat;
                            r_timer <= c_ALARM_T;
                        end
                    end
                end
                S_UNLOCK: begin
                    // Expiry takes priority over a coincident ADMIN key
                    if (w_expire) begin
                        r_state <= S_WAIT;
                        r_timer <= 20'd0;
                    end else if (w_admin) begin
                        r_state <= S_ADMIN;
                        r_timer <= 20'd0;
                        r_code  <= c_BLANK;
                        r_cnt   <= 3'd0;
                    end else if (i_tick) begin
                        r_timer <= r_timer - 20'd1;
                    end
                end
                S_ERROR: begin
                    if (w_expire) begin
                        r_state <= S_WAIT;
                        r_timer <= 20'd0;
                    end else if (i_tick) begin
                        r_timer <= r_timer - 20'd1;
                    end
                end
                S_ALARM: begin
                    if (w_expire) begin
                        r_state <= S_WAIT;
                        r_timer <= 20'd0;
                        r_err   <= 4'd0;
                    end else if (i_tick) begin
                        r_timer <= r_timer - 20'd1;
                    end
                end
                S_ADMIN: begin
                    if (w_digit && !w_full) begin
                        r_code <= w_code_shift;
                        r_cnt  <= r_cnt + 3'd1;
                    end else if (w_enter && w_full) begin
                        r_pwd   <= r_code;
                        r_state <= S_WAIT;
                        r_code  <= c_BLANK;
                        r_cnt   <= 3'd0;
                    end else if (w_clear) begin
                        if (r_cnt == 3'd0) begin
                            r_state <= S_WAIT;
                        end
                        r_code <= c_BLANK;
                        r_cnt  <= 3'd0;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_code  <= c_BLANK;
                    r_cnt   <= 3'd0;
                    r_timer <= 20'd0;
                end
            endcase
        end
    end

    assign o_current_state = r_state;
    assign o_code          = r_code;
    assign o_error_times   = r_err;
    assign o_count_clk     = r_timer;
    assign o_door_open     = (r_state == S_UNLOCK);

endmodule

`default_nettype wire

// File: tb/tb_lock_ctrl_fsm.sv
// ============================================================================
// Module   : tb_lock_ctrl_fsm
// Purpose  : Directed, table-driven self-checking bench for lock_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_ctrl_fsm;

    localparam logic [2:0] WAIT = 3'd0, INPUT = 3'd1, UNLOCK = 3'd2,
                           ERROR = 3'd3, ALARM = 3'd4, ADMIN = 3'd5;
    localparam logic [3:0] K_ENT = 4'hA, K_CLR = 4'hB, K_ADM = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        kv = 1'b0;
    logic [3:0]  key = 4'd0;
    logic [2:0]  st;
    logic [15:0] code;
    logic [3:0]  err;
    logic [19:0] cnt;
    logic        door;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lock_ctrl_fsm #(
        .RESET_PWD   (16'h1234),
        .MAX_ERR     (3),
        .UNLOCK_TICKS(20),
        .ERROR_TICKS (10),
        .ALARM_TICKS (10)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tick         (tick),
        .i_key_valid    (kv),
        .i_key_code     (key),
        .o_current_state(st),
        .o_code         (code),
        .o_error_times  (err),
        .o_count_clk    (cnt),
        .o_door_open    (door)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        logic        tick;
        logic [2:0]  st;
        logic [15:0] code;
        logic [3:0]  err;
        logic [19:0] cnt;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string nm, input logic [2:0] es, input logic [15:0] ec,
                         input logic [3:0] ee, input logic [19:0] en);
        n_cmp++;
        if (st !== es) begin
            n_bad++;
            $display("FAIL %s state: got %0d want %0d", nm, st, es);
        end
        n_cmp++;
        if (code !== ec) begin
            n_bad++;
            $display("FAIL %s code: got %h want %h", nm, code, ec);
        end
        n_cmp++;
        if (err !== ee) begin
            n_bad++;
            $display("FAIL %s errors: got %0d want %0d", nm, err, ee);
        end
        n_cmp++;
        if (cnt !== en) begin
            n_bad++;
            $display("FAIL %s count: got %0d want %0d", nm, cnt, en);
        end
        n_cmp++;
        if (door !== (es == UNLOCK)) begin
            n_bad++;
            $display("FAIL %s door: got %0b want %0b", nm, door, (es == UNLOCK));
        end
    endtask

    task automatic step(input logic v, input logic [3:0] k, input logic t);
        @(negedge clk);
        kv   = v;
        key  = k;
        tick = t;
        @(posedge clk);
        #1;
        kv   = 1'b0;
        tick = 1'b0;
    endtask

    task automatic press(input string nm, input logic [3:0] k, input logic [2:0] es,
                         input logic [15:0] ec, input logic [3:0] ee, input logic [19:0] en);
        step(1'b1, k, 1'b0);
        check(nm, es, ec, ee, en);
    endtask

    // Enter four digits of c starting from a blank code, checking each shift
    task automatic digits4(input string nm, input logic [15:0] c, input logic [2:0] es,
                           input logic [3:0] ee, input logic [19:0] en);
        logic [15:0] exp_code;
        exp_code = 16'hAAAA;
        for (int i = 3; i >= 0; i--) begin
            exp_code = {exp_code[11:0], c[i*4 +: 4]};
            press(nm, c[i*4 +: 4], es, exp_code, ee, en);
        end
    endtask

    // Apply n ticks from a given starting count; reaching zero returns to WAIT
    task automatic run_ticks(input string nm, input int n, input int start,
                             input logic [2:0] es, input logic [3:0] ee_run,
                             input logic [3:0] ee_end);
        for (int i = 1; i <= n; i++) begin
            step(1'b0, 4'd0, 1'b1);
            if (start - i > 0)
                check(nm, es, 16'hAAAA, ee_run, 20'(start - i));
            else
                check(nm, WAIT, 16'hAAAA, ee_end, 20'd0);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check(nm, WAIT, 16'hAAAA, 4'd0, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'd1,  1'b0, INPUT,  16'hAAA1, 4'd0, 20'd0};
        vt[1]  = '{1'b1, 4'd2,  1'b0, INPUT,  16'hAA12, 4'd0, 20'd0};
        vt[2]  = '{1'b1, K_ENT, 1'b0, INPUT,  16'hAA12, 4'd0, 20'd0};
        vt[3]  = '{1'b1, K_CLR, 1'b0, INPUT,  16'hAAAA, 4'd0, 20'd0};
        vt[4]  = '{1'b1, 4'd5,  1'b0, INPUT,  16'hAAA5, 4'd0, 20'd0};
        vt[5]  = '{1'b1, K_CLR, 1'b0, INPUT,  16'hAAAA, 4'd0, 20'd0};
        vt[6]  = '{1'b1, 4'd1,  1'b0, INPUT,  16'hAAA1, 4'd0, 20'd0};
        vt[7]  = '{1'b1, 4'd2,  1'b0, INPUT,  16'hAA12, 4'd0, 20'd0};
        vt[8]  = '{1'b1, 4'd3,  1'b0, INPUT,  16'hA123, 4'd0, 20'd0};
        vt[9]  = '{1'b1, 4'd4,  1'b0, INPUT,  16'h1234, 4'd0, 20'd0};
        vt[10] = '{1'b1, 4'd5,  1'b0, INPUT,  16'h1234, 4'd0, 20'd0};
        vt[11] = '{1'b0, 4'd0,  1'b1, INPUT,  16'h1234, 4'd0, 20'd0};
        vt[12] = '{1'b1, K_ENT, 1'b0, UNLOCK, 16'hAAAA, 4'd0, 20'd20};
        vt[13] = '{1'b0, 4'd0,  1'b1, UNLOCK, 16'hAAAA, 4'd0, 20'd19};
        vt[14] = '{1'b1, 4'd7,  1'b0, UNLOCK, 16'hAAAA, 4'd0, 20'd19};

        do_reset("reset");
        step(1'b1, K_ENT, 1'b0);
        check("wait_ignores_enter", WAIT, 16'hAAAA, 4'd0, 20'd0);

        for (int i = 0; i < 15; i++) begin
            step(vt[i].kv, vt[i].key, vt[i].tick);
            check($sformatf("vec%0d", i), vt[i].st, vt[i].code, vt[i].err, vt[i].cnt);
        end
        run_ticks("unlock_timer", 19, 19, UNLOCK, 4'd0, 4'd0);

        digits4("wrong1", 16'h1235, INPUT, 4'd0, 20'd0);
        press("wrong1_enter", K_ENT, ERROR, 16'hAAAA, 4'd1, 20'd10);
        press("error_key_ignored", 4'd1, ERROR, 16'hAAAA, 4'd1, 20'd10);
        run_ticks("error_timer", 10, 10, ERROR, 4'd1, 4'd1);

        digits4("wrong2", 16'h1235, INPUT, 4'd1, 20'd0);
        press("wrong2_enter", K_ENT, ERROR, 16'hAAAA, 4'd2, 20'd10);
        run_ticks("error_timer2", 10, 10, ERROR, 4'd2, 4'd2);
        digits4("wrong3", 16'h0000, INPUT, 4'd2, 20'd0);
        press("alarm_enter", K_ENT, ALARM, 16'hAAAA, 4'd3, 20'd10);
        press("alarm_digit_ignored", 4'd1, ALARM, 16'hAAAA, 4'd3, 20'd10);
        press("alarm_admin_ignored", K_ADM, ALARM, 16'hAAAA, 4'd3, 20'd10);
        run_ticks("alarm_timer", 10, 10, ALARM, 4'd3, 4'd0);

        digits4("unlock2", 16'h1234, INPUT, 4'd0, 20'd0);
        press("unlock2_enter", K_ENT, UNLOCK, 16'hAAAA, 4'd0, 20'd20);
        press("enter_admin", K_ADM, ADMIN, 16'hAAAA, 4'd0, 20'd0);
        step(1'b0, 4'd0, 1'b1);
        check("admin_tick_ignored", ADMIN, 16'hAAAA, 4'd0, 20'd0);
        press("admin_d9", 4'd9, ADMIN, 16'hAAA9, 4'd0, 20'd0);
        press("admin_clear_partial", K_CLR, ADMIN, 16'hAAAA, 4'd0, 20'd0);
        digits4("admin_pwd", 16'h9876, ADMIN, 4'd0, 20'd0);
        press("admin_extra_digit", 4'd5, ADMIN, 16'h9876, 4'd0, 20'd0);
        press("admin_store", K_ENT, WAIT, 16'hAAAA, 4'd0, 20'd0);
        digits4("old_pwd", 16'h1234, INPUT, 4'd0, 20'd0);
        press("old_pwd_enter", K_ENT, ERROR, 16'hAAAA, 4'd1, 20'd10);
        run_ticks("error_timer3", 10, 10, ERROR, 4'd1, 4'd1);
        digits4("new_pwd", 16'h9876, INPUT, 4'd1, 20'd0);
        press("new_pwd_enter", K_ENT, UNLOCK, 16'hAAAA, 4'd0, 20'd20);

        press("admin2", K_ADM, ADMIN, 16'hAAAA, 4'd0, 20'd0);
        press("admin_enter_short", K_ENT, ADMIN, 16'hAAAA, 4'd0, 20'd0);
        press("admin_abort", K_CLR, WAIT, 16'hAAAA, 4'd0, 20'd0);
        digits4("kept_pwd", 16'h9876, INPUT, 4'd0, 20'd0);
        press("kept_pwd_enter", K_ENT, UNLOCK, 16'hAAAA, 4'd0, 20'd20);
        run_ticks("unlock_pre_expiry", 19, 20, UNLOCK, 4'd0, 4'd0);
        step(1'b1, K_ADM, 1'b1);
        check("expiry_beats_admin", WAIT, 16'hAAAA, 4'd0, 20'd0);

        digits4("pre_reset", 16'h9876, INPUT, 4'd0, 20'd0);
        press("pre_reset_enter", K_ENT, UNLOCK, 16'hAAAA, 4'd0, 20'd20);
        run_ticks("pre_reset_ticks", 3, 20, UNLOCK, 4'd0, 4'd0);
        do_reset("reset_mid_unlock");
        digits4("reset_pwd", 16'h1234, INPUT, 4'd0, 20'd0);
        press("reset_pwd_enter", K_ENT, UNLOCK, 16'hAAAA, 4'd0, 20'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
